// File: rtl/write_split_pipeline.sv
// Write-side retiming stage ahead of the write address translators: per-thread split bits,
// round-robin thread counter, DEPTH-stage write pipeline. Optional WRITE_SPLIT_COUNT_EN adds split_write_count.
module write_split_pipeline #(
    parameter int unsigned THREAD_COUNT     = 8,
    parameter int unsigned THREAD_WIDTH     = 3,
    parameter int unsigned WRITE_ADDR_WIDTH = 12,
    parameter int unsigned WORD_WIDTH       = 36,
    parameter int unsigned DEPTH            = 2,
    parameter logic [WRITE_ADDR_WIDTH-1:0] SPLIT_CONFIG_ADDR = WRITE_ADDR_WIDTH'(12'hFFF)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_write_en,
    input  logic [WRITE_ADDR_WIDTH-1:0] in_write_addr,
    input  logic [WORD_WIDTH-1:0]       in_write_data,
    output logic                        out_write_en,
    output logic [WRITE_ADDR_WIDTH-1:0] out_write_addr,
    output logic [WORD_WIDTH-1:0]       out_write_data,
    output logic                        out_split,
    output logic [THREAD_WIDTH-1:0]     out_thread,
    output logic [THREAD_WIDTH-1:0]     in_thread
`ifdef WRITE_SPLIT_COUNT_EN
    ,
    output logic [15:0]                 split_write_count
`endif
);

    localparam logic [THREAD_WIDTH-1:0] LAST_THREAD = THREAD_WIDTH'(THREAD_COUNT - 1);

    typedef struct packed {
        logic                        en;
        logic [WRITE_ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0]       data;
        logic                        split;
        logic [THREAD_WIDTH-1:0]     thread;
    } slot_t;

    logic [THREAD_COUNT-1:0] split_reg;
    slot_t                   pipe [DEPTH];
    slot_t                   capture_c;
    logic                    config_hit_c;

    // Stage-0 payload; the split bit is read before this cycle's config update lands.
    always_comb begin
        config_hit_c     = in_write_en && (in_write_addr == SPLIT_CONFIG_ADDR);
        capture_c        = '0;
        capture_c.en     = in_write_en && !config_hit_c;
        capture_c.addr   = in_write_addr;
        capture_c.data   = in_write_data;
        capture_c.split  = split_reg[in_thread];
        capture_c.thread = in_thread;
    end

    // Free-running round-robin thread id.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_thread <= '0;
        end else if (in_thread == LAST_THREAD) begin
            in_thread <= '0;
        end else begin
            in_thread <= in_thread + THREAD_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            split_reg <= '0;
        end else if (config_hit_c) begin
            split_reg[in_thread] <= in_write_data[0];
        end
    end

    // Fixed-latency shift pipeline; suppressed config writes keep their slot with en=0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= capture_c;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign out_write_en   = pipe[DEPTH-1].en;
    assign out_write_addr = pipe[DEPTH-1].addr;
    assign out_write_data = pipe[DEPTH-1].data;
    assign out_split      = pipe[DEPTH-1].split;
    assign out_thread     = pipe[DEPTH-1].thread;

`ifdef WRITE_SPLIT_COUNT_EN
    // Saturating count of split writes leaving the stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            split_write_count <= '0;
        end else if (out_write_en && out_split && (split_write_count != 16'hFFFF)) begin
            split_write_count <= split_write_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_write_split_pipeline.sv
// Randomized self-checking bench for write_split_pipeline against a queue-based reference model.
module tb_write_split_pipeline;

    localparam int unsigned TC    = 8;
    localparam int unsigned TW    = 3;
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 36;
    localparam int unsigned DEPTH = 2;
    localparam logic [AW-1:0] CFG = 12'hFFF;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          split;
        logic [TW-1:0] thread;
    } item_t;

    logic          clock;
    logic          reset_n;
    logic          in_write_en;
    logic [AW-1:0] in_write_addr;
    logic [DW-1:0] in_write_data;
    logic          out_write_en;
    logic [AW-1:0] out_write_addr;
    logic [DW-1:0] out_write_data;
    logic          out_split;
    logic [TW-1:0] out_thread;
    logic [TW-1:0] in_thread;
`ifdef WRITE_SPLIT_COUNT_EN
    logic [15:0]   split_write_count;
`endif

    write_split_pipeline #(
        .THREAD_COUNT(TC), .THREAD_WIDTH(TW), .WRITE_ADDR_WIDTH(AW),
        .WORD_WIDTH(DW), .DEPTH(DEPTH), .SPLIT_CONFIG_ADDR(CFG)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_write_en(in_write_en), .in_write_addr(in_write_addr), .in_write_data(in_write_data),
        .out_write_en(out_write_en), .out_write_addr(out_write_addr), .out_write_data(out_write_data),
        .out_split(out_split), .out_thread(out_thread), .in_thread(in_thread)
`ifdef WRITE_SPLIT_COUNT_EN
        , .split_write_count(split_write_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed and expected views: {en, addr, data, split, out_thread, in_thread}
    wire [1+AW+DW+1+TW+TW-1:0] obs = {out_write_en, out_write_addr, out_write_data,
                                      out_split, out_thread, in_thread};
    logic [1+AW+DW+1+TW+TW-1:0] exp_vec;

    int            checks;
    int            errors;
    item_t         q[$];
    int            thr_m;
    logic [TC-1:0] split_m;
    int            cnt_m;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < int'(DEPTH); i++) q.push_back('0);
        thr_m   = 0;
        split_m = '0;
        cnt_m   = 0;
        exp_vec = '0;
    endtask

    // Drive one cycle at the falling edge, advance the model at the rising edge, return at the next falling edge.
    task automatic step(input logic en, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        item_t it;
        logic  hit;
        in_write_en   = en;
        in_write_addr = addr;
        in_write_data = data;
        hit = en && (addr == CFG);
        it  = '{en && !hit, addr, data, split_m[thr_m], TW'(thr_m)};
        @(posedge clock);
        if (q[0].en && q[0].split && cnt_m != 65535) cnt_m++;
        q.push_back(it);
        void'(q.pop_front());
        if (hit) split_m[thr_m] = data[0];
        thr_m = (thr_m + 1) % int'(TC);
        @(negedge clock);
        exp_vec = {q[0].en, q[0].addr, q[0].data, q[0].split, q[0].thread, TW'(thr_m)};
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 32'hFFE));
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic idle_until(input int t);
        while (thr_m != t) step(1'b0, AW'($urandom()), rand_data());
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_write_en = 1'b0; in_write_addr = '0; in_write_data = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_hold got %h exp 0", obs);
        end
        reset_n = 1'b1;
        model_reset();
        checks++;
        if (obs !== exp_vec) begin
            errors++; $display("FAIL reset_release got %h exp %h", obs, exp_vec);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, '0);
            checks++;
            if (obs !== exp_vec || in_thread !== TW'((i + 1) % int'(TC))) begin
                errors++; $display("FAIL idle_thread got %h exp %h", obs, exp_vec);
            end
        end
    endtask

    task automatic test_plain_write();
        idle_until(3);
        step(1'b1, 12'h123, 36'h5A);
        for (int i = 0; i < int'(DEPTH) - 1; i++) step(1'b0, '0, '0);
        checks++;
        if ({out_write_en, out_write_addr, out_write_data, out_split, out_thread} !==
            {1'b1, 12'h123, 36'h5A, 1'b0, 3'd3}) begin
            errors++; $display("FAIL plain_write got %h", obs);
        end
        checks++;
        if (obs !== exp_vec) begin
            errors++; $display("FAIL plain_write_model got %h exp %h", obs, exp_vec);
        end
    endtask

    task automatic test_split_config();
        idle_until(5);
        step(1'b1, CFG, 36'h1);
        for (int i = 1; i <= 8 + int'(DEPTH); i++) begin
            if (thr_m == 4)      step(1'b1, 12'h044, rand_data());
            else if (thr_m == 5) step(1'b1, 12'h0C4, rand_data());
            else                 step(1'b0, rand_addr(), rand_data());
            checks++;
            if (obs !== exp_vec) begin
                errors++; $display("FAIL split_cfg_model got %h exp %h", obs, exp_vec);
            end
            if (i == int'(DEPTH) - 1) begin
                checks++;
                if (out_write_en !== 1'b0 || out_thread !== 3'd5 || out_write_addr !== CFG) begin
                    errors++; $display("FAIL cfg_slot got en=%b thr=%0d addr=%h", out_write_en, out_thread, out_write_addr);
                end
            end
            if (out_write_en && out_thread == 3'd4) begin
                checks++;
                if (out_split !== 1'b0) begin
                    errors++; $display("FAIL thread4_split got %b exp 0", out_split);
                end
            end
            if (out_write_en && out_thread == 3'd5) begin
                checks++;
                if (out_split !== 1'b1 || out_write_addr !== 12'h0C4) begin
                    errors++; $display("FAIL thread5_split got %b/%h exp 1/0c4", out_split, out_write_addr);
                end
            end
        end
    endtask

    task automatic test_split_inflight();
        idle_until(2);
        step(1'b1, 12'h200, rand_data());
        for (int i = 1; i <= 8 + int'(DEPTH); i++) begin
            if (i == 8) step(1'b1, CFG, 36'h1);
            else        step(1'b0, rand_addr(), rand_data());
            checks++;
            if (obs !== exp_vec) begin
                errors++; $display("FAIL inflight_model got %h exp %h", obs, exp_vec);
            end
            if (out_write_en && out_thread == 3'd2) begin
                checks++;
                if (out_split !== 1'b0 || out_write_addr !== 12'h200) begin
                    errors++; $display("FAIL inflight_split got %b/%h exp 0/200", out_split, out_write_addr);
                end
            end
        end
    endtask

    task automatic test_cfg_consecutive();
        for (int i = 0; i < int'(TC); i++) begin
            step(1'b1, CFG, rand_data());
            checks++;
            if (obs !== exp_vec) begin
                errors++; $display("FAIL cfg_consec got %h exp %h", obs, exp_vec);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, CFG, rand_data());
        end
        for (int i = 0; i < int'(TC) + int'(DEPTH); i++) begin
            step(1'b1, rand_addr(), rand_data());
            checks++;
            if (obs !== exp_vec) begin
                errors++; $display("FAIL cfg_readback got %h exp %h", obs, exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        seen = 0;
        for (int i = 0; i < int'(DEPTH); i++) step(1'b0, '0, '0);
        for (int i = 0; i < 100 + int'(DEPTH) - 1; i++) begin
            if (i < 100) step(1'b1, rand_addr(), rand_data());
            else         step(1'b0, '0, '0);
            if (out_write_en) seen++;
            checks++;
            if (obs !== exp_vec) begin
                errors++; $display("FAIL b2b_model got %h exp %h", obs, exp_vec);
            end
        end
        checks++;
        if (seen != 100) begin
            errors++; $display("FAIL b2b_count got %0d exp 100", seen);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 7) == 0) ? CFG : AW'($urandom());
            step(1'($urandom()), a, rand_data());
            checks++;
            if (obs !== exp_vec) begin
                errors++; $display("FAIL random got %h exp %h", obs, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, rand_addr(), rand_data());
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_mid_now got %h exp 0", obs);
        end
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        in_write_en = 1'b0;
        for (int i = 0; i < int'(DEPTH) + 3; i++) begin
            step(1'b0, '0, '0);
            checks++;
            if (obs !== exp_vec || out_write_en !== 1'b0) begin
                errors++; $display("FAIL reset_mid_after got %h exp %h", obs, exp_vec);
            end
        end
    endtask

`ifdef WRITE_SPLIT_COUNT_EN
    task automatic test_split_count();
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (split_write_count !== 16'd0) begin
            errors++; $display("FAIL count_reset got %0d exp 0", split_write_count);
        end
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < int'(TC); i++) step(1'b1, CFG, 36'h1);
        for (int i = 0; i < 100; i++) step(1'b1, rand_addr(), rand_data());
        for (int i = 0; i < int'(DEPTH) + 1; i++) step(1'b0, '0, '0);
        checks++;
        if (split_write_count !== 16'd100 || cnt_m != 100) begin
            errors++; $display("FAIL count_100 got %0d exp 100", split_write_count);
        end
        for (int i = 0; i < 65500; i++) step(1'b1, rand_addr(), rand_data());
        for (int i = 0; i < int'(DEPTH) + 1; i++) step(1'b0, '0, '0);
        checks++;
        if (split_write_count !== 16'hFFFF || cnt_m != 65535) begin
            errors++; $display("FAIL count_sat got %h exp ffff", split_write_count);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_plain_write();
        test_split_config();
        test_split_inflight();
        test_cfg_consecutive();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef WRITE_SPLIT_COUNT_EN
        test_split_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
